// File: rtl/vga_pixel_selector_if.sv
// Sprite move port between a move-command source and vga_pixel_selector.
//   move_valid : source requests a one-step sprite move
//   move_dir   : 00 up, 01 down, 10 left, 11 right
//   move_ready : selector can take a command (no move pending)
interface vga_pixel_selector_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (output move_valid, output move_dir, input move_ready);
  modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/vga_pixel_selector.sv
// VGA timing generator and colour-code classifier feeding mux_color.
// Ports:
//   clk, rst      : pixel clock, synchronous active-high reset
//   test_en       : force code 01 over the whole active area
//   mv            : sprite move port (slave side)
//   selector      : 00 background, 01 test, 10 grid, 11 sprite (1-cycle latency)
//   hsync, vsync  : active-low syncs (2-cycle latency, aligned with mux_color)
//   video_on      : active-area flag, aligned with hsync
//   frame_start   : one-cycle pulse for pixel (0,0), aligned with hsync
//   pixel_x/y     : current counters, undelayed
module vga_pixel_selector #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned LINE_X0  = 213,
  parameter int unsigned LINE_X1  = 426,
  parameter int unsigned LINE_Y0  = 160,
  parameter int unsigned LINE_Y1  = 320,
  parameter int unsigned LINE_W   = 4,
  parameter int unsigned SPR_SIZE = 32,
  parameter int unsigned SPR_STEP = 8,
  parameter int unsigned SPR_X0   = 304,
  parameter int unsigned SPR_Y0   = 224
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       test_en,
  vga_pixel_selector_if.slave        mv,
  output logic [1:0]                 selector,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_on,
  output logic                       frame_start,
  output logic [9:0]                 pixel_x,
  output logic [9:0]                 pixel_y
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] LX0      = 10'(LINE_X0);
  localparam logic [9:0] LX0_E    = 10'(LINE_X0 + LINE_W);
  localparam logic [9:0] LX1      = 10'(LINE_X1);
  localparam logic [9:0] LX1_E    = 10'(LINE_X1 + LINE_W);
  localparam logic [9:0] LY0      = 10'(LINE_Y0);
  localparam logic [9:0] LY0_E    = 10'(LINE_Y0 + LINE_W);
  localparam logic [9:0] LY1      = 10'(LINE_Y1);
  localparam logic [9:0] LY1_E    = 10'(LINE_Y1 + LINE_W);
  localparam logic [9:0] SIZE     = 10'(SPR_SIZE);
  localparam logic [9:0] STEP     = 10'(SPR_STEP);
  localparam logic [9:0] SX_MAX   = 10'(H_ACTIVE - SPR_SIZE);
  localparam logic [9:0] SY_MAX   = 10'(V_ACTIVE - SPR_SIZE);
  localparam logic [9:0] SX_RST   = 10'(SPR_X0);
  localparam logic [9:0] SY_RST   = 10'(SPR_Y0);

  typedef enum logic {MV_IDLE, MV_PEND} mv_state_e;

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic [1:0] dir_q, dir_d;
  mv_state_e  state_q, state_d;
  logic       apply_slot, apply;
  logic       active, hs_raw, vs_raw, fs_raw, spr_hit, grid_hit;
  logic [1:0] code_d, sel_q;
  logic       hs1_q, hs2_q, vs1_q, vs2_q, von1_q, von2_q, fs1_q, fs2_q;

  // Counters
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // Stage 0 classification
  always_comb begin
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw   = !((h_q >= HS_START) && (h_q < HS_END));
    vs_raw   = !((v_q >= VS_START) && (v_q < VS_END));
    fs_raw   = (h_q == '0) && (v_q == '0);
    spr_hit  = (h_q >= sx_q) && (h_q < sx_q + SIZE) &&
               (v_q >= sy_q) && (v_q < sy_q + SIZE);
    grid_hit = ((h_q >= LX0) && (h_q < LX0_E)) || ((h_q >= LX1) && (h_q < LX1_E)) ||
               ((v_q >= LY0) && (v_q < LY0_E)) || ((v_q >= LY1) && (v_q < LY1_E));
    if (!active)       code_d = 2'b00;
    else if (test_en)  code_d = 2'b01;
    else if (spr_hit)  code_d = 2'b11;
    else if (grid_hit) code_d = 2'b10;
    else               code_d = 2'b00;
  end

  // Move FSM: next state
  assign apply_slot = (h_q == '0) && (v_q == V_ACT);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      MV_IDLE: if (mv.move_valid) begin
        state_d = MV_PEND;
        dir_d   = mv.move_dir;
      end
      MV_PEND: if (apply_slot) state_d = MV_IDLE;
      default: state_d = MV_IDLE;
    endcase
  end

  // Move FSM: outputs. An accept landing on the apply slot is still IDLE
  // that cycle, so it naturally waits for the next frame's slot.
  always_comb begin
    mv.move_ready = (state_q == MV_IDLE);
    apply         = (state_q == MV_PEND) && apply_slot;
  end

  // Clamped sprite position update
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (apply) begin
      case (dir_q)
        2'b00:   sy_d = (sy_q < STEP) ? '0 : sy_q - STEP;
        2'b01:   sy_d = (sy_q > SY_MAX - STEP) ? SY_MAX : sy_q + STEP;
        2'b10:   sx_d = (sx_q < STEP) ? '0 : sx_q - STEP;
        default: sx_d = (sx_q > SX_MAX - STEP) ? SX_MAX : sx_q + STEP;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= MV_IDLE;
      dir_q   <= '0;
      sx_q    <= SX_RST;
      sy_q    <= SY_RST;
      sel_q   <= '0;
      hs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vs2_q   <= 1'b1;
      von1_q  <= 1'b0;
      von2_q  <= 1'b0;
      fs1_q   <= 1'b0;
      fs2_q   <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sel_q   <= code_d;
      hs1_q   <= hs_raw;
      hs2_q   <= hs1_q;
      vs1_q   <= vs_raw;
      vs2_q   <= vs1_q;
      von1_q  <= active;
      von2_q  <= von1_q;
      fs1_q   <= fs_raw;
      fs2_q   <= fs1_q;
    end
  end

  assign selector    = sel_q;
  assign hsync       = hs2_q;
  assign vsync       = vs2_q;
  assign video_on    = von2_q;
  assign frame_start = fs2_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;

endmodule

// File: tb/tb_vga_pixel_selector.sv
// Directed bench for vga_pixel_selector on a reduced 56x32 raster so that
// whole frames (and multi-frame move sequences) fit a short run.
module tb_vga_pixel_selector;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;   // 56
  localparam int VT = VA + VF + VS + VB;   // 32
  localparam int FRAME = HT * VT;          // 1792

  logic       clk = 1'b0;
  logic       rst;
  logic       test_en;
  logic [1:0] selector;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  vga_pixel_selector_if mif();

  always #20 clk = ~clk;

  vga_pixel_selector #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_X0(8), .LINE_X1(28), .LINE_Y0(5), .LINE_Y1(18), .LINE_W(2),
    .SPR_SIZE(8), .SPR_STEP(2), .SPR_X0(16), .SPR_Y0(10)
  ) dut (
    .clk(clk), .rst(rst), .test_en(test_en), .mv(mif),
    .selector(selector), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_pixel(input int x, input int y, input string tag);
    int n = 0;
    while (!(int'(pixel_x) == x && int'(pixel_y) == y) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check({tag, "_reach"}, int'(int'(pixel_x) == x && int'(pixel_y) == y), 1);
  endtask

  // Selector for pixel (x,y) is visible one cycle after the counter shows it.
  task automatic sel_at(input int x, input int y, input int exp, input string tag);
    wait_pixel(x, y, tag);
    step();
    check(tag, int'(selector), exp);
  endtask

  task automatic send_move(input logic [1:0] dir);
    mif.move_valid = 1'b1;
    mif.move_dir   = dir;
    step();
    mif.move_valid = 1'b0;
  endtask

  initial begin
    #(100000 * 40);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int px[$], py[$];
    int m_x, m_hs, m_vs, m_von, m_fs;
    int c_hs, c_vs, c_von, c_fs;
    int ex, ey;

    rst = 1'b1; test_en = 1'b0;
    mif.move_valid = 1'b0; mif.move_dir = 2'b00;
    repeat (3) @(posedge clk);
    step();
    check("rst_x", int'(pixel_x), 0);
    check("rst_y", int'(pixel_y), 0);
    check("rst_sel", int'(selector), 0);
    check("rst_hs", int'(hsync), 1);
    check("rst_vs", int'(vsync), 1);
    check("rst_von", int'(video_on), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_ready", int'(mif.move_ready), 1);
    rst = 1'b0;

    // One full frame of timing, starting at pixel (0,0).
    m_x = 0; m_hs = 0; m_vs = 0; m_von = 0; m_fs = 0;
    c_hs = 0; c_vs = 0; c_von = 0; c_fs = 0;
    for (int k = 0; k < FRAME + 2; k++) begin
      if (int'(pixel_x) != k % HT || int'(pixel_y) != (k / HT) % VT) m_x++;
      px.push_back(int'(pixel_x));
      py.push_back(int'(pixel_y));
      if (k >= 2) begin
        ex = px[k-2]; ey = py[k-2];
        if (hsync != !(ex >= HA + HF && ex < HA + HF + HS)) m_hs++;
        if (vsync != !(ey >= VA + VF && ey < VA + VF + VS)) m_vs++;
        if (video_on != (ex < HA && ey < VA)) m_von++;
        if (frame_start != (ex == 0 && ey == 0)) m_fs++;
        if (!hsync) c_hs++;
        if (!vsync) c_vs++;
        if (video_on) c_von++;
        if (frame_start) c_fs++;
      end
      step();
    end
    check("cnt_seq", m_x, 0);
    check("hs_align", m_hs, 0);
    check("vs_align", m_vs, 0);
    check("von_align", m_von, 0);
    check("fs_align", m_fs, 0);
    check("hs_low_cycles", c_hs, VT * HS);
    check("vs_low_cycles", c_vs, VS * HT);
    check("von_cycles", c_von, HA * VA);
    check("fs_pulses", c_fs, 1);

    // Classification, sprite at (16,10), grid x 8/28, y 5/18, width 2.
    sel_at(29, 0, 2, "grid_x1_last");
    sel_at(30, 0, 0, "grid_x1_after");
    sel_at(8, 2, 2, "grid_x0");
    sel_at(9, 2, 2, "grid_x0_last");
    sel_at(10, 2, 0, "grid_x0_after");
    sel_at(3, 6, 2, "grid_y0");
    sel_at(45, 6, 0, "hblank_on_line");
    sel_at(3, 7, 0, "grid_y0_after");
    sel_at(16, 10, 3, "spr_tl");
    sel_at(24, 10, 0, "spr_right_out");
    sel_at(23, 17, 3, "spr_br");
    sel_at(16, 18, 2, "spr_below_line");
    sel_at(8, 26, 0, "vblank_on_line");

    test_en = 1'b1;
    sel_at(8, 2, 1, "test_grid");
    sel_at(3, 7, 1, "test_bg");
    sel_at(45, 7, 0, "test_hblank");
    sel_at(16, 10, 1, "test_spr");
    sel_at(8, 26, 0, "test_vblank");
    test_en = 1'b0;

    // Move right; a second request while busy must be ignored.
    wait_pixel(0, 1, "mv_r");
    check("ready_idle", int'(mif.move_ready), 1);
    send_move(2'b11);
    check("ready_drop", int'(mif.move_ready), 0);
    mif.move_valid = 1'b1; mif.move_dir = 2'b00;
    repeat (5) step();
    mif.move_valid = 1'b0;
    wait_pixel(0, VA, "mv_apply");
    check("ready_at_apply", int'(mif.move_ready), 0);
    step();
    check("ready_back", int'(mif.move_ready), 1);
    sel_at(18, 9, 0, "mvr_above");
    sel_at(17, 10, 0, "mvr_left_out");
    sel_at(18, 10, 3, "mvr_tl");
    sel_at(25, 17, 3, "mvr_br");
    sel_at(26, 17, 0, "mvr_right_out");

    // Reset mid-frame with a move pending.
    wait_pixel(0, 1, "rst_mv");
    send_move(2'b11);
    wait_pixel(20, 12, "rst_pt");
    rst = 1'b1;
    step();
    check("mid_rst_x", int'(pixel_x), 0);
    check("mid_rst_y", int'(pixel_y), 0);
    check("mid_rst_ready", int'(mif.move_ready), 1);
    check("mid_rst_hs", int'(hsync), 1);
    check("mid_rst_vs", int'(vsync), 1);
    rst = 1'b0;
    sel_at(15, 10, 0, "rst_spr_left");
    sel_at(16, 10, 3, "rst_spr_home");
    wait_pixel(0, VA + 1, "rst_nf");
    sel_at(16, 10, 3, "rst_discard_home");
    sel_at(24, 10, 0, "rst_discard_right");

    // Up moves from y=10 with step 2: clamps at 0 after five.
    for (int i = 0; i < 7; i++) begin
      wait_pixel(0, 1, "up");
      send_move(2'b00);
      check("up_ready_drop", int'(mif.move_ready), 0);
      wait_pixel(0, VA + 1, "up_done");
      if (i == 3) begin
        sel_at(16, 1, 0, "up4_above");
        sel_at(16, 2, 3, "up4_top");
      end
    end
    sel_at(15, 0, 0, "up_clamp_left");
    sel_at(16, 0, 3, "up_clamp_top");
    sel_at(16, 5, 3, "spr_over_grid");
    sel_at(16, 7, 3, "up_clamp_bottom");
    sel_at(16, 8, 0, "up_clamp_below");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_pixel_selector.md
Name: vga_pixel_selector

Overview:
Generates 640x480@60 VGA timing from a 25 MHz pixel clock. Classifies each pixel into the 2-bit colour-select code consumed by mux_color: 00 background, 01 test/white, 10 grid lines, 11 sprite. Owns a movable sprite whose position is updated through a valid/ready move port, applied only during vertical blanking. Sync outputs are delayed so they line up with mux_color's registered colour output.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (total 800)
V_ACTIVE, 480, visible lines
V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (total 525)
LINE_X0 / LINE_X1, 213 / 426, left edge of the vertical grid lines
LINE_Y0 / LINE_Y1, 160 / 320, top edge of the horizontal grid lines
LINE_W, 4, grid line thickness in pixels
SPR_SIZE, 32, sprite square side
SPR_STEP, 8, pixels moved per accepted command
SPR_X0 / SPR_Y0, 304 / 224, sprite top-left position after reset

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  synchronous reset, active-high
test_en  in  1  forces code 01 over the entire active area
move_valid  in  1  move request
move_dir  in  2  00 up, 01 down, 10 left, 11 right
move_ready  out  1  high when no move is pending
selector  out  2  colour code to mux_color
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
video_on  out  1  active-area flag, aligned with hsync
frame_start  out  1  one-cycle pulse, aligned with hsync
pixel_x  out  10  current h counter, undelayed
pixel_y  out  10  current v counter, undelayed

Behaviour:
- Reset (rst high at a clk edge) loads:
  - h_cnt=0, v_cnt=0
  - selector=00, hsync=1, vsync=1, video_on=0, frame_start=0
  - move_ready=1, pending move cleared
  - sprite position = (SPR_X0, SPR_Y0)
- Reset mid-frame discards any pending move. Timing restarts at (0,0) on the next cycle.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..524 and wraps to 0.
- Stage 0 (counter cycle n):
  - active = h_cnt<640 && v_cnt<480.
  - hsync_raw low for h_cnt in 656..751.
  - vsync_raw low for v_cnt in 490..491.
- Code priority (stage 0):
  - not active: 00.
  - test_en: 01.
  - sprite hit: 11. Hit means sx<=h_cnt<sx+SPR_SIZE and sy<=v_cnt<sy+SPR_SIZE.
  - grid hit: 10. Hit means h_cnt in [LINE_X0, LINE_X0+LINE_W) or [LINE_X1, LINE_X1+LINE_W), or v_cnt in [LINE_Y0, LINE_Y0+LINE_W) or [LINE_Y1, LINE_Y1+LINE_W).
  - otherwise: 00.
- Latency and alignment:
  - selector is registered and appears at cycle n+1.
  - hsync, vsync and video_on are registered twice and appear at n+2, matching mux_color's one-cycle register.
  - frame_start is 1 at n+2 for the (0,0) pixel only.
- Move handshake:
  - A move is accepted on a cycle with move_valid && move_ready. dir is latched, and move_ready drops on the next cycle.
  - The pending move is applied on the cycle with h_cnt==0 && v_cnt==480 (start of vblank). move_ready returns to 1 the following cycle.
  - At most one move is applied per frame. Valid asserted while ready is low is ignored; no queueing.
  - If acceptance and the apply cycle coincide, the move is applied in the next frame.
- Sprite position arithmetic:
  - 10-bit unsigned, clamped: sx in [0, 608], sy in [0, 448].
  - Up from sy<8 gives 0. Down from sy>440 gives 448. Same rule on x.
- Sprite and grid are never drawn outside the active area.

Test Plan:
- Reset, then run 420000 cycles -> hsync period 800 cycles (low 96); vsync period 420000 cycles (low 1600); video_on high 640 of every 800 cycles on lines 0..479; frame_start once per frame.
- Idle after reset, pixel (304,224) -> selector 11 one cycle later. Pixel (213,10) -> 10. Pixel (100,100) -> 00. Pixel (700,100) -> 00.
- test_en=1 -> selector 01 at every active pixel, including sprite and line positions; 00 in blanking.
- Send move right in frame k -> move_ready low until the cycle after (h=0, v=480); frame k+1 sprite spans x 312..343. A second move_valid while not ready is ignored.
- Send move up 30 times from reset -> sy reaches 0 after 28 moves and stays 0; selector 11 at (304,0).
- Assert rst at (h=400, v=200) with a move pending -> next cycle counters are (0,0), move_ready=1, sprite back at (304,224), hsync=vsync=1.
